// File: rtl/cursor_aim_ctrl.sv
// Cursor aiming controller: frame-paced cursor movement with hold acceleration,
// edge-triggered fire, and return-to-anchor once the scene is idle again.
// Optional build macro CURSOR_DIAG_EN: when defined both axes may move in one
// frame; otherwise only one axis moves per frame and vertical wins.
module cursor_aim_ctrl #(
  parameter int unsigned FRAME_W      = 640,
  parameter int unsigned FRAME_H      = 480,
  parameter int unsigned OBJ_SIZE     = 32,
  parameter int unsigned MARGIN       = 15,
  parameter int unsigned FP_SHIFT     = 6,
  parameter int unsigned STEP_MIN     = 1,
  parameter int unsigned STEP_MAX     = 4,
  parameter int unsigned ACCEL_FRAMES = 8,
  parameter int unsigned INIT_X       = 50,
  parameter int unsigned INIT_Y       = 185
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               key_fire,
  input  logic [10:0]        anchor_x,
  input  logic [10:0]        anchor_y,
  input  logic               can_cont,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               fire_pulse,
  output logic               shut_down,
  output logic [1:0]         state_o
);

  localparam int unsigned POS_W    = $clog2((FRAME_W << FP_SHIFT) + 1);
  localparam int unsigned ANC_W    = 11 + FP_SHIFT;
  localparam int unsigned CALC_W   = ((POS_W > ANC_W) ? POS_W : ANC_W) + 1;
  localparam int unsigned HOLD_SAT = (STEP_MAX - STEP_MIN) * ACCEL_FRAMES;
  localparam int unsigned HOLD_W   = $clog2(HOLD_SAT + 2);
  localparam int unsigned STEP_W   = $clog2(STEP_MAX + 1);

  localparam logic [CALC_W-1:0] X_LO = CALC_W'(MARGIN << FP_SHIFT);
  localparam logic [CALC_W-1:0] X_HI = CALC_W'((FRAME_W - 1 - MARGIN - OBJ_SIZE) << FP_SHIFT);
  localparam logic [CALC_W-1:0] Y_LO = CALC_W'(MARGIN << FP_SHIFT);
  localparam logic [CALC_W-1:0] Y_HI = CALC_W'((FRAME_H - 1 - MARGIN - OBJ_SIZE) << FP_SHIFT);

  typedef enum logic [1:0] {
    S_AIM    = 2'd0,
    S_FIRED  = 2'd1,
    S_WAIT   = 2'd2,
    S_RETURN = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [HOLD_W-1:0]  hold_q, hold_d, eff_hold;
  logic [3:0]         dir_q, dir_d, dir;
  logic               fire_prev_q, fire_prev_d;
  logic               fire_pulse_q, fire_pulse_d;
  logic               shut_st_q, shut_st_d;
  logic               seen_low_q, seen_low_d;
  logic               hi_seen_q, hi_seen_d;
  logic [31:0]        step_raw;
  logic [STEP_W-1:0]  step_px;
  logic [CALC_W-1:0]  step_fp;
  logic               v_act, h_en;

  // Step one axis by step toward inc/dec, landing exactly on the bound if crossed.
  function automatic logic [CALC_W-1:0] move_axis(
    input logic [CALC_W-1:0] pos, input logic inc, input logic dec,
    input logic [CALC_W-1:0] step, input logic [CALC_W-1:0] lo,
    input logic [CALC_W-1:0] hi);
    logic [CALC_W-1:0] r;
    r = pos;
    if (inc && !dec) r = ((pos + step) > hi) ? hi : (pos + step);
    else if (dec && !inc) r = (pos < (lo + step)) ? lo : (pos - step);
    return r;
  endfunction

  // Clamp a fixed-point coordinate into [lo, hi].
  function automatic logic [CALC_W-1:0] clamp(
    input logic [CALC_W-1:0] v, input logic [CALC_W-1:0] lo,
    input logic [CALC_W-1:0] hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Direction set, acceleration step and axis-enable for this frame.
  always_comb begin
    dir      = {key_up, key_down, key_left, key_right};
    eff_hold = ((dir != 4'd0) && (dir == dir_q)) ? hold_q : '0;
    step_raw = STEP_MIN + (32'(eff_hold) / ACCEL_FRAMES);
    step_px  = (step_raw > STEP_MAX) ? STEP_W'(STEP_MAX) : STEP_W'(step_raw);
    step_fp  = CALC_W'(step_px) << FP_SHIFT;
    v_act    = key_up ^ key_down;
`ifdef CURSOR_DIAG_EN
    h_en     = 1'b1;
`else
    h_en     = !v_act;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= S_AIM;
    else         state_q <= state_d;
  end

  // Next-state logic, advanced only on frame pulses.
  always_comb begin
    state_d = state_q;
    if (startOfFrame) begin
      unique case (state_q)
        S_AIM:    if (key_fire && !fire_prev_q) state_d = S_FIRED;
        S_FIRED:  if (!key_fire) state_d = S_WAIT;
        S_WAIT:   if (can_cont && (seen_low_q || hi_seen_q)) state_d = S_RETURN;
        S_RETURN: state_d = S_AIM;
        default:  state_d = S_AIM;
      endcase
    end
  end

  // Datapath and output next values for the frame.
  always_comb begin
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    hold_d       = hold_q;
    dir_d        = dir_q;
    fire_prev_d  = fire_prev_q;
    fire_pulse_d = 1'b0;
    shut_st_d    = shut_st_q;
    seen_low_d   = seen_low_q;
    hi_seen_d    = hi_seen_q;
    if (startOfFrame) begin
      fire_prev_d  = key_fire;
      fire_pulse_d = (state_q == S_AIM) && key_fire && !fire_prev_q;
      shut_st_d    = (state_d == S_FIRED) || (state_d == S_WAIT);
      seen_low_d   = 1'b0;
      hi_seen_d    = 1'b0;
      dir_d        = 4'd0;
      hold_d       = '0;
      unique case (state_q)
        S_AIM: begin
          dir_d   = dir;
          hold_d  = (dir == 4'd0) ? '0 :
                    ((eff_hold >= HOLD_W'(HOLD_SAT)) ? HOLD_W'(HOLD_SAT) : eff_hold + 1'b1);
          pos_y_d = POS_W'(move_axis(CALC_W'(pos_y_q), key_down, key_up, step_fp, Y_LO, Y_HI));
          if (h_en)
            pos_x_d = POS_W'(move_axis(CALC_W'(pos_x_q), key_right, key_left, step_fp, X_LO, X_HI));
        end
        S_WAIT: begin
          seen_low_d = seen_low_q || !can_cont;
          hi_seen_d  = can_cont;
        end
        S_RETURN: begin
          pos_x_d = POS_W'(clamp(CALC_W'(anchor_x) << FP_SHIFT, X_LO, X_HI));
          pos_y_d = POS_W'(clamp(CALC_W'(anchor_y) << FP_SHIFT, Y_LO, Y_HI));
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; fire history resets to "held" so a held key cannot fire.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pos_x_q      <= POS_W'(INIT_X << FP_SHIFT);
      pos_y_q      <= POS_W'(INIT_Y << FP_SHIFT);
      hold_q       <= '0;
      dir_q        <= 4'd0;
      fire_prev_q  <= 1'b1;
      fire_pulse_q <= 1'b0;
      shut_st_q    <= 1'b0;
      seen_low_q   <= 1'b0;
      hi_seen_q    <= 1'b0;
    end else begin
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      hold_q       <= hold_d;
      dir_q        <= dir_d;
      fire_prev_q  <= fire_prev_d;
      fire_pulse_q <= fire_pulse_d;
      shut_st_q    <= shut_st_d;
      seen_low_q   <= seen_low_d;
      hi_seen_q    <= hi_seen_d;
    end
  end

  // Pixel outputs; shut_down also follows a live can_cont=0, including in reset.
  assign topLeftX   = 11'(pos_x_q >> FP_SHIFT);
  assign topLeftY   = 11'(pos_y_q >> FP_SHIFT);
  assign fire_pulse = fire_pulse_q;
  assign shut_down  = shut_st_q | ~can_cont;
  assign state_o    = state_q;

endmodule

// File: tb/tb_cursor_aim_ctrl.sv
// Directed self-checking bench for cursor_aim_ctrl (default parameters).
module tb_cursor_aim_ctrl;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic               sof = 1'b0;
  logic               k_up = 1'b0, k_down = 1'b0, k_left = 1'b0, k_right = 1'b0, k_fire = 1'b0;
  logic [10:0]        anc_x = 11'd0, anc_y = 11'd0;
  logic               can_cont = 1'b1;
  logic signed [10:0] tlx, tly;
  logic               fire_pulse, shut_down;
  logic [1:0]         state_o;

  int total = 0;
  int passed = 0;
  int failed = 0;
  int fire_cnt = 0;
  int x_exp, y_exp, step;

  cursor_aim_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof),
    .key_up(k_up), .key_down(k_down), .key_left(k_left), .key_right(k_right),
    .key_fire(k_fire), .anchor_x(anc_x), .anchor_y(anc_y), .can_cont(can_cont),
    .topLeftX(tlx), .topLeftY(tly), .fire_pulse(fire_pulse),
    .shut_down(shut_down), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Count clock cycles with fire_pulse high.
  always @(negedge clk) if (fire_pulse) fire_cnt <= fire_cnt + 1;

  task automatic chk(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One frame pulse, then settle and sample away from the rising edge.
  task automatic frame();
    @(negedge clk); sof = 1'b1;
    @(negedge clk); sof = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  initial begin
    // Reset state, shut_down follows can_cont during reset.
    can_cont = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", int'(state_o), 0);
    chk("rst_x", int'(tlx), 50);
    chk("rst_y", int'(tly), 185);
    chk("rst_fire", int'(fire_pulse), 0);
    chk("rst_shut_cc0", int'(shut_down), 1);
    can_cont = 1'b1;
    #1;
    chk("rst_shut_cc1", int'(shut_down), 0);
    resetN = 1'b1;

    // Idle frames.
    frames(10);
    chk("idle_x", int'(tlx), 50);
    chk("idle_y", int'(tly), 185);
    chk("idle_state", int'(state_o), 0);
    chk("idle_fire", fire_cnt, 0);

    // Right held 20 frames: steps 1x8, 2x8, 3x4.
    k_right = 1'b1;
    x_exp = 50;
    for (int i = 0; i < 20; i++) begin
      step = (i < 8) ? 1 : ((i < 16) ? 2 : 3);
      x_exp += step;
      frame();
      chk($sformatf("accel_x%0d", i), int'(tlx), x_exp);
    end
    chk("accel_end_x", int'(tlx), 86);
    k_right = 1'b0;
    frame();
    chk("release_x", int'(tlx), 86);
    k_right = 1'b1;
    frame();
    chk("repress_x", int'(tlx), 87);
    k_right = 1'b0;
    frame();

    // Fire, wait with can_cont low then high, return to anchor.
    k_fire = 1'b1;
    frame();
    chk("fire_state", int'(state_o), 1);
    chk("fire_cnt1", fire_cnt, 1);
    chk("fired_shut", int'(shut_down), 1);
    frames(2);
    chk("fired_hold_state", int'(state_o), 1);
    chk("fired_hold_cnt", fire_cnt, 1);
    k_fire = 1'b0;
    frame();
    chk("wait_state", int'(state_o), 2);
    chk("wait_shut", int'(shut_down), 1);
    anc_x = 11'd300; anc_y = 11'd200;
    can_cont = 1'b0;
    frame();
    chk("wait_low_state", int'(state_o), 2);
    can_cont = 1'b1;
    frame();
    chk("return_state", int'(state_o), 3);
    frame();
    chk("aim_state", int'(state_o), 0);
    chk("anchor_x", int'(tlx), 300);
    chk("anchor_y", int'(tly), 200);
    chk("aim_shut", int'(shut_down), 0);

    // Return via can_cont high for two frames, anchor (20,400).
    k_fire = 1'b1;
    frame();
    chk("fire2_cnt", fire_cnt, 2);
    k_fire = 1'b0;
    anc_x = 11'd20; anc_y = 11'd400;
    frame();
    chk("wait2_state", int'(state_o), 2);
    frame();
    chk("wait2_hi1_state", int'(state_o), 2);
    frame();
    chk("return2_state", int'(state_o), 3);
    frame();
    chk("aim2_x", int'(tlx), 20);
    chk("aim2_y", int'(tly), 400);

    // Left from 20 clamps at 15.
    k_left = 1'b1;
    for (int i = 0; i < 7; i++) begin
      frame();
      chk($sformatf("left_x%0d", i), int'(tlx), (20 - (i + 1) < 15) ? 15 : 20 - (i + 1));
    end
    k_left = 1'b0;
    frame();

    // Down from 400 saturates at 432.
    k_down = 1'b1;
    y_exp = 400;
    for (int i = 0; i < 22; i++) begin
      step = (i < 8) ? 1 : ((i < 16) ? 2 : 3);
      y_exp = (y_exp + step > 432) ? 432 : y_exp + step;
      frame();
      chk($sformatf("down_y%0d", i), int'(tly), y_exp);
    end
    chk("down_x", int'(tlx), 15);
    k_down = 1'b0;
    frame();

    // Cancelled vertical, then vertical priority (or diagonal).
    k_up = 1'b1; k_down = 1'b1; k_right = 1'b1;
    frame();
    chk("cancel_x1", int'(tlx), 16);
    chk("cancel_y1", int'(tly), 432);
    frame();
    chk("cancel_x2", int'(tlx), 17);
    k_down = 1'b0;
    frame();
    chk("prio_y1", int'(tly), 431);
`ifdef CURSOR_DIAG_EN
    chk("prio_x1", int'(tlx), 18);
`else
    chk("prio_x1", int'(tlx), 17);
`endif
    frame();
    chk("prio_y2", int'(tly), 430);
`ifdef CURSOR_DIAG_EN
    chk("prio_x2", int'(tlx), 19);
`else
    chk("prio_x2", int'(tlx), 17);
`endif
    k_up = 1'b0; k_right = 1'b0;
    frame();

    // Anchor clamp, fire held through RETURN must not re-fire.
    k_fire = 1'b1;
    frame();
    chk("fire3_cnt", fire_cnt, 3);
    k_fire = 1'b0;
    anc_x = 11'd1000; anc_y = 11'd2;
    frame();
    k_fire = 1'b1;
    frames(3);
    chk("clamp_x", int'(tlx), 592);
    chk("clamp_y", int'(tly), 15);
    chk("clamp_state", int'(state_o), 0);
    frame();
    chk("held_no_refire_state", int'(state_o), 0);
    chk("held_no_refire_cnt", fire_cnt, 3);
    k_fire = 1'b0;
    k_right = 1'b1;
    frame();
    chk("xmax_x", int'(tlx), 592);
    k_right = 1'b0;
    frame();

    // Async reset during WAIT with fire held.
    k_fire = 1'b1;
    frame();
    k_fire = 1'b0;
    frame();
    chk("wait3_state", int'(state_o), 2);
    k_fire = 1'b1;
    @(negedge clk); #3;
    resetN = 1'b0;
    #1;
    chk("arst_state", int'(state_o), 0);
    chk("arst_x", int'(tlx), 50);
    chk("arst_y", int'(tly), 185);
    @(negedge clk); #1;
    resetN = 1'b1;
    frames(3);
    chk("post_rst_state", int'(state_o), 0);
    chk("post_rst_cnt", fire_cnt, 4);
    k_fire = 1'b0;
    frame();
    k_fire = 1'b1;
    frame();
    chk("refire_state", int'(state_o), 1);
    chk("refire_cnt", fire_cnt, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
